// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Imported by the receiver and reused by the future transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer (2 flops) plus history flop with falling-edge detect.
// Latency 2 cycles pin-to-sync; no backpressure. All flops reset to 1 (idle line).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            hist   <= 1'b1;
        end else begin
            meta   <= din;
            sync_q <= meta;
            hist   <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = hist & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN), mid-bit sampling, one-entry valid/ready holding register.
// Outputs register one cycle after the stop-bit sample; a full holding register drops the new byte and pulses overrun.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       par_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             sync_rx;
    logic             fall;
    logic             par_bad;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (uart_rx),
        .sync_out (sync_rx),
        .fall     (fall)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    // Even parity: data plus parity bit must have an even number of ones.
    assign par_bad = ^{shift_reg, par_bit};
    assign par_err = par_err_q;
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // A delivery in STOP below overrides this clear when both coincide.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt       <= '0;
                        shift_reg <= {sync_rx, shift_reg[7:1]};
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        par_bit <= sync_rx;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt       <= '0;
                        frame_err <= ~sync_rx;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= par_bad;
`endif
                        if (sync_rx && !par_bad) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                        // Leaving at mid-stop-bit gives half a bit of margin for the next start edge.
                        state <= sync_rx ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    cnt <= '0;
                    if (sync_rx) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
